string_reader: RTL and testbench

STRING_READER -- requirements
Module: string_reader

---
 rtl/string_pkg.sv | 16 +
 rtl/string_reader.sv | 102 ++++++++++
 tb/tb_string_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/string_pkg.sv
// Shared definitions for the string RAM and its reader: capacity, address width
// and the reader state encoding.
package string_pkg;

  localparam int DEPTH  = 80;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } reader_state_t;

endpackage

// File: rtl/string_reader.sv
// Streams the first min(str_len, DEPTH) characters of a registered-read string RAM
// to a valid/ready consumer, one character per FETCH/LOAD/SEND round.
module string_reader #(
  parameter int DEPTH  = string_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] str_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // One extra bit so a length equal to a power-of-two DEPTH stays representable.
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  string_pkg::reader_state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [LEN_W-1:0]  str_len_ext;
  logic [LEN_W-1:0]  len_clamped;
  logic              last_char;

  assign str_len_ext = LEN_W'(str_len);
  assign len_clamped = (str_len_ext > DEPTH_L) ? DEPTH_L : str_len_ext;
  assign last_char   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tx_data_d = tx_data_q;
    // Abort outranks every other event once a transfer is under way.
    if (abort && (state_q != string_pkg::ST_IDLE)) begin
      state_d = string_pkg::ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        string_pkg::ST_IDLE: begin
          if (start && !abort) begin
            len_d   = len_clamped;
            idx_d   = '0;
            state_d = (len_clamped == '0) ? string_pkg::ST_DONE : string_pkg::ST_FETCH;
          end
        end
        string_pkg::ST_FETCH: state_d = string_pkg::ST_LOAD;
        string_pkg::ST_LOAD: begin
          tx_data_d = rd_data;
          state_d   = string_pkg::ST_SEND;
        end
        string_pkg::ST_SEND: begin
          if (tx_ready) begin
            if (last_char) begin
              state_d = string_pkg::ST_DONE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = string_pkg::ST_FETCH;
            end
          end
        end
        string_pkg::ST_DONE: begin
          state_d = string_pkg::ST_IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = string_pkg::ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= string_pkg::ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign rd_addr  = idx_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == string_pkg::ST_SEND);
  assign busy     = (state_q != string_pkg::ST_IDLE);
  assign done     = (state_q == string_pkg::ST_DONE);

endmodule

// File: tb/tb_string_reader.sv
// Directed plus randomized bench for string_reader with a registered-read RAM model
// and a reference model: byte i of a transfer is mem[i], for i < min(str_len, DEPTH).
module tb_string_reader;

  localparam int DEPTH = string_pkg::DEPTH;
  localparam int AW    = string_pkg::ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] str_len = '0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done;

  string_reader dut (
    .clk(clk), .rst(rst), .start(start), .str_len(str_len), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [DEPTH];
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: collects accepted bytes, done pulses, and checks SEND stays stable while stalled.
  logic [7:0]    acc_q[$];
  int            acc_cyc[$];
  int            acc_addr[$];
  int            done_cnt = 0, done_cyc = -1, first_valid_cyc = -1, busy_cnt = 0, start_cyc = 0;
  logic          pend = 1'b0, pend_abort = 1'b0;
  logic [7:0]    pend_data = 8'h00;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && !pend_abort) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(pend_data));
        chk("hold_addr", 32'(rd_addr), 32'(pend_addr));
      end
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_valid && tx_ready && !abort) begin
        acc_q.push_back(tx_data);
        acc_cyc.push_back(cyc);
        acc_addr.push_back(int'(rd_addr));
      end
      pend       = tx_valid && !tx_ready;
      pend_abort = abort;
      pend_data  = tx_data;
      pend_addr  = rd_addr;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    acc_cyc.delete();
    acc_addr.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    busy_cnt = 0;
  endtask

  task automatic pulse_start(input int len);
    str_len   = AW'(len);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input int len);
    int n_exp;
    n_exp = (len > DEPTH) ? DEPTH : len;
    chk({tag, " count"}, 32'(acc_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < acc_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), 32'(acc_q[i]), 32'(mem[i]));
      chk($sformatf("%s addr%0d", tag, i), 32'(acc_addr[i]), 32'(i));
    end
  endtask

  // rmode: 0 = ready always high, 1 = random ready, 2 = stall first SEND for 10 cycles.
  task automatic run_xfer(input string tag, input int len, input int rmode, input int mid_start_at);
    bit ok;
    clear_mon();
    ok = 1'b0;
    tx_ready = (rmode == 0);
    pulse_start(len);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      if (rmode == 1) tx_ready = 1'($urandom_range(0, 1));
      if (rmode == 2) tx_ready = (first_valid_cyc >= 0) && (cyc >= first_valid_cyc + 10);
      if (i == mid_start_at) begin
        start   = 1'b1;
        str_len = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tick(3);
    chk({tag, " done_seen"}, 32'(ok), 32'd1);
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check_bytes(tag, len);
    if (len > 0) begin
      chk({tag, " first_valid_latency"}, 32'(first_valid_cyc - start_cyc), 32'd3);
      if (acc_cyc.size() > 0)
        chk({tag, " done_after_last"}, 32'(done_cyc), 32'(acc_cyc[acc_cyc.size()-1] + 1));
      if (rmode == 0)
        for (int i = 1; i < acc_cyc.size(); i++)
          chk($sformatf("%s rate%0d", tag, i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
      if (rmode == 2 && acc_cyc.size() > 0)
        chk({tag, " stall_len"}, 32'(acc_cyc[0] - first_valid_cyc), 32'd10);
    end else begin
      chk({tag, " zero_no_valid"}, 32'(first_valid_cyc), 32'hFFFF_FFFF);
      chk({tag, " zero_done_time"}, 32'(done_cyc - start_cyc), 32'd1);
      chk({tag, " zero_busy_cycles"}, 32'(busy_cnt), 32'd1);
    end
    $display("xfer %s len=%0d bytes=%0d done=%0d", tag, len, acc_q.size(), done_cnt);
  endtask

  task automatic load_hello();
    logic [39:0] hello;
    hello = "HELLO";
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = hello[39-8*i -: 8];
  endtask

  initial begin
    int rlen;
    bit ok;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    // Reset values
    tick(2);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;
    tick(2);

    load_hello();
    run_xfer("hello", 5, 0, -1);
    run_xfer("zero", 0, 0, -1);
    run_xfer("stall", 3, 2, -1);
    chk("stall first byte", 32'(mem[0]), 32'h48);
    run_xfer("hello_midstart", 5, 0, 4);

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd101;
    run_xfer("clamp90", 90, 0, -1);

    // Start together with abort in IDLE is ignored
    clear_mon();
    start = 1'b1; abort = 1'b1; str_len = AW'(4);
    tick();
    start = 1'b0; abort = 1'b0;
    tick(3);
    chk("start_abort busy", 32'(busy_cnt), 32'd0);
    chk("start_abort done", 32'(done_cnt), 32'd0);

    // Abort while fetching the second character, then a fresh transfer
    load_hello();
    clear_mon();
    tx_ready = 1'b1;
    pulse_start(5);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (acc_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("abort reached_2nd", 32'(ok), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort tx_valid", 32'(tx_valid), 32'd0);
    chk("abort rd_addr", 32'(rd_addr), 32'd0);
    tick(5);
    chk("abort no_done", 32'(done_cnt), 32'd0);
    $display("xfer abort bytes=%0d done=%0d", acc_q.size(), done_cnt);
    run_xfer("after_abort", 2, 0, -1);

    // Asynchronous reset in the middle of a stalled SEND
    clear_mon();
    tx_ready = 1'b0;
    pulse_start(4);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("rstmid reached_send", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid rd_addr", 32'(rd_addr), 32'd0);
    chk("rstmid tx_data", 32'(tx_data), 32'd0);
    chk("rstmid tx_valid", 32'(tx_valid), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid done", 32'(done), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("rstmid idle_busy", 32'(busy), 32'd0);
    chk("rstmid no_done", 32'(done_cnt), 32'd0);
    $display("xfer rst_mid done=%0d", done_cnt);
    run_xfer("after_rst", 4, 0, -1);

    // Randomized transfers with random backpressure and stray start/str_len while busy
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      rlen = (t == 0) ? 0 : int'($urandom_range(0, 100));
      run_xfer($sformatf("rand%0d", t), rlen, 1, (rlen > 0) ? 2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
